mem_stage_ctrl: RTL and testbench

Parametrised load/store stage controller for the pipelined core. It sits between the execute stage and the data memory, and replaces the single-request `mem_stage` counter with a queue of up to `depth_p` outstanding valid/yumi transactions. Responses return in order. Each completed transaction drives a register-file write-back port that the network can block.

---
 rtl/mem_stage_ctrl_pkg.sv | 27 ++
 rtl/mem_stage_ctrl_fifo.sv | 53 +++++
 rtl/mem_stage_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the load/store stage controller: request/pending structs and pointer sizing.
package mem_stage_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic              wen;
        logic              byte_not_word;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } mem_req_s;

    typedef struct packed {
        logic            is_load;
        logic            is_byte;
        logic [RD_W-1:0] rd;
    } mem_pend_s;

    // A single-entry queue still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_fifo.sv
// In-order pending-transaction FIFO; push on request acceptance, pop on response consumption.
module mem_pend_fifo
    import mem_stage_ctrl_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 2,
    localparam int PTR_W  = ptr_width(depth_p),
    localparam int CNT_W  = $clog2(depth_p + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] wdata,
    input  logic               pop,
    output logic [width_p-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic [width_p-1:0] mem [depth_p];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push_ok, pop_ok;

    assign full    = (count == CNT_W'(depth_p));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_W'(depth_p - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_W'(depth_p - 1)) ? '0 : rd_ptr + 1'b1;
            if (push_ok & ~pop_ok)
                count <= count + 1'b1;
            else if (pop_ok & ~push_ok)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Load/store stage controller with up to depth_p outstanding in-order memory transactions.
// MEM_STAGE_BYTE_SEXT_EN: defined -> byte loads sign-extend from bit 7, else zero-extend.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int data_width_p = DATA_W,
    parameter int addr_width_p = ADDR_W,
    parameter int rd_width_p   = RD_W,
    parameter int depth_p      = 2,
    localparam int CNT_W       = $clog2(depth_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    input  logic                    req_wen_i,
    input  logic                    req_byte_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [data_width_p-1:0] req_wdata_i,
    input  logic [rd_width_p-1:0]   req_rd_i,
    output logic                    req_ready_o,
    output logic                    mem_valid_o,
    output logic                    mem_wen_o,
    output logic                    mem_byte_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0] mem_wdata_o,
    input  logic                    mem_yumi_i,
    input  logic                    mem_rvalid_i,
    input  logic [data_width_p-1:0] mem_rdata_i,
    output logic                    mem_ryumi_o,
    input  logic                    wb_block_i,
    output logic                    wb_valid_o,
    output logic                    wb_wen_o,
    output logic [rd_width_p-1:0]   wb_rd_o,
    output logic [data_width_p-1:0] wb_data_o,
    output logic                    busy_o,
    output logic                    err_o
);

`ifdef MEM_STAGE_BYTE_SEXT_EN
    localparam bit BYTE_SEXT = 1'b1;
`else
    localparam bit BYTE_SEXT = 1'b0;
`endif

    mem_req_s          req;
    mem_pend_s         pend_in, head;
    logic              hold_v, hold_wen, hold_byte;
    logic [addr_width_p-1:0] hold_addr;
    logic [data_width_p-1:0] hold_wdata;
    logic              fifo_full, fifo_empty, accept;
    logic [CNT_W-1:0]  pend_count;
    logic [data_width_p-1:0] byte_ext;

    assign req.wen           = req_wen_i;
    assign req.byte_not_word = req_byte_i;
    assign req.addr          = req_addr_i;
    assign req.wdata         = req_wdata_i;
    assign req.rd            = req_rd_i;

    assign pend_in.is_load = ~req.wen;
    assign pend_in.is_byte = req.byte_not_word;
    assign pend_in.rd      = req.rd;

    // Readiness depends only on state and the request-side yumi, never on the response side.
    assign req_ready_o = ~fifo_full & (~hold_v | mem_yumi_i);
    assign accept      = req_valid_i & req_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v     <= 1'b0;
            hold_wen   <= 1'b0;
            hold_byte  <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (accept) begin
            hold_v     <= 1'b1;
            hold_wen   <= req.wen;
            hold_byte  <= req.byte_not_word;
            hold_addr  <= req.addr;
            hold_wdata <= req.wdata;
        end else if (mem_yumi_i) begin
            hold_v     <= 1'b0;
        end
    end

    assign mem_valid_o = hold_v;
    assign mem_wen_o   = hold_wen;
    assign mem_byte_o  = hold_byte;
    assign mem_addr_o  = hold_addr;
    assign mem_wdata_o = hold_wdata;

    mem_pend_fifo #(
        .width_p ($bits(mem_pend_s)),
        .depth_p (depth_p)
    ) u_pend (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (pend_in),
        .pop   (mem_ryumi_o),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pend_count)
    );

    assign mem_ryumi_o = mem_rvalid_i & ~fifo_empty & ~wb_block_i;
    assign wb_valid_o  = mem_ryumi_o;
    assign wb_wen_o    = wb_valid_o & head.is_load;
    assign wb_rd_o     = head.rd;
    assign byte_ext    = {{(data_width_p-8){BYTE_SEXT & mem_rdata_i[7]}}, mem_rdata_i[7:0]};

    always_comb begin
        wb_data_o = '0;
        if (head.is_load)
            wb_data_o = head.is_byte ? byte_ext : mem_rdata_i;
    end

    assign busy_o = hold_v | (pend_count != '0);

    // Stray responses or yumis are flagged but otherwise ignored.
    always_ff @(posedge clk) begin
        if (reset)
            err_o <= 1'b0;
        else if ((mem_rvalid_i & fifo_empty) | (mem_yumi_i & ~hold_v))
            err_o <= 1'b1;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_mem_stage_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_wen_i, req_byte_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        req_ready_o, mem_valid_o, mem_wen_o, mem_byte_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_yumi_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_ryumi_o, wb_block_i, wb_valid_o, wb_wen_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o, err_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_ctrl #(
        .data_width_p(32), .addr_width_p(32), .rd_width_p(5), .depth_p(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .req_ready_o(req_ready_o),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_ryumi_o(mem_ryumi_o),
        .wb_block_i(wb_block_i), .wb_valid_o(wb_valid_o), .wb_wen_o(wb_wen_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_load;
        bit         is_byte;
        logic [4:0] rd;
    } pend_t;

    pend_t       pq[$];
    bit          m_hold_v, m_wen, m_byte, m_err;
    logic [31:0] m_addr, m_wdata;

    function automatic logic [31:0] fmt_byte(input logic [31:0] d);
        logic [31:0] r;
        r = d & 32'hFF;
`ifdef MEM_STAGE_BYTE_SEXT_EN
        if (r >= 32'h80) r = r | 32'hFFFF_FF00;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_i = 0; req_wen_i = 0; req_byte_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0;
        mem_yumi_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; wb_block_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        pq.delete();
        m_hold_v = 0;
        m_err = 0;
    endtask

    task automatic load_req(input logic [4:0] rd, input logic [31:0] addr, input bit is_byte);
        req_valid_i = 1; req_wen_i = 0; req_byte_i = is_byte;
        req_addr_i = addr; req_wdata_i = 0; req_rd_i = rd;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_tests++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid_o); end
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
        n_tests++; if (mem_ryumi_o !== 1'b0) begin n_fail++; $display("FAIL reset_ryumi: got %b want 0", mem_ryumi_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    endtask

    task automatic test_single_load();
        do_reset();
        load_req(5'd3, 32'h10, 0);
        #2;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", req_ready_o); end
        tick();
        idle(); mem_yumi_i = 1;
        #2;
        n_tests++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_wen_o !== 1'b0)
            begin n_fail++; $display("FAIL single_mem_req: got v=%b a=%h w=%b want 1/10/0", mem_valid_o, mem_addr_o, mem_wen_o); end
        tick();
        idle(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #2;
        n_tests++; if (wb_valid_o !== 1'b1 || wb_wen_o !== 1'b1 || wb_rd_o !== 5'd3 || wb_data_o !== 32'hDEADBEEF)
            begin n_fail++; $display("FAIL single_wb: got v=%b w=%b rd=%0d d=%h want 1/1/3/deadbeef", wb_valid_o, wb_wen_o, wb_rd_o, wb_data_o); end
        tick();
        idle();
        #2;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy_o); end
    endtask

    task automatic test_full_queue();
        do_reset();
        load_req(5'd1, 32'h100, 0);
        tick();
        load_req(5'd2, 32'h104, 0); mem_yumi_i = 1;
        #2;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_second_ready: got %b want 1", req_ready_o); end
        tick();
        load_req(5'd4, 32'h108, 0); mem_yumi_i = 1;
        #2;
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_third_ready: got %b want 0", req_ready_o); end
        tick();
        mem_yumi_i = 0;
        #2;
        n_tests++; if (req_ready_o !== 1'b0 || mem_valid_o !== 1'b0)
            begin n_fail++; $display("FAIL full_still_blocked: got rdy=%b mv=%b want 0/0", req_ready_o, mem_valid_o); end
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_000A;
        #2;
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle_ready: got %b want 0", req_ready_o); end
        n_tests++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd1)
            begin n_fail++; $display("FAIL full_first_commit: got v=%b rd=%0d want 1/1", wb_valid_o, wb_rd_o); end
        tick();
        mem_rvalid_i = 0;
        #2;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", req_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_wb_block();
        do_reset();
        load_req(5'd7, 32'h40, 0);
        tick();
        idle(); mem_yumi_i = 1;
        tick();
        idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h1357_2468; wb_block_i = 1;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_tests++; if (mem_ryumi_o !== 1'b0 || wb_valid_o !== 1'b0 || busy_o !== 1'b1)
                begin n_fail++; $display("FAIL block_cycle%0d: got ry=%b wv=%b busy=%b want 0/0/1", c, mem_ryumi_o, wb_valid_o, busy_o); end
            tick();
        end
        wb_block_i = 0;
        #2;
        n_tests++; if (mem_ryumi_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_rd_o !== 5'd7 || wb_data_o !== 32'h1357_2468)
            begin n_fail++; $display("FAIL block_commit: got ry=%b wv=%b rd=%0d d=%h want 1/1/7/13572468", mem_ryumi_o, wb_valid_o, wb_rd_o, wb_data_o); end
        tick();
        idle();
        #2;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL block_busy_after: got %b want 0", busy_o); end
    endtask

    task automatic test_byte_ext();
        logic [31:0] want;
`ifdef MEM_STAGE_BYTE_SEXT_EN
        want = 32'hFFFF_FFF0;
`else
        want = 32'h0000_00F0;
`endif
        do_reset();
        load_req(5'd2, 32'h13, 1);
        tick();
        idle(); mem_yumi_i = 1;
        #2;
        n_tests++; if (mem_byte_o !== 1'b1) begin n_fail++; $display("FAIL byte_mem_byte: got %b want 1", mem_byte_o); end
        tick();
        idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h0000_00F0;
        #2;
        n_tests++; if (wb_data_o !== want || wb_wen_o !== 1'b1)
            begin n_fail++; $display("FAIL byte_ext: got d=%h w=%b want %h/1", wb_data_o, wb_wen_o, want); end
        tick();
        idle();
    endtask

    task automatic test_store_load();
        do_reset();
        req_valid_i = 1; req_wen_i = 1; req_byte_i = 0;
        req_addr_i = 32'h20; req_wdata_i = 32'hCAFE_F00D; req_rd_i = 5'd9;
        tick();
        load_req(5'd4, 32'h24, 0); mem_yumi_i = 1;
        #2;
        n_tests++; if (mem_wen_o !== 1'b1 || mem_wdata_o !== 32'hCAFE_F00D || req_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL sl_store_req: got w=%b d=%h rdy=%b want 1/cafef00d/1", mem_wen_o, mem_wdata_o, req_ready_o); end
        tick();
        idle(); mem_yumi_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #2;
        n_tests++; if (wb_valid_o !== 1'b1 || wb_wen_o !== 1'b0 || wb_data_o !== 32'h0 || mem_wen_o !== 1'b0)
            begin n_fail++; $display("FAIL sl_store_commit: got v=%b w=%b d=%h mw=%b want 1/0/0/0", wb_valid_o, wb_wen_o, wb_data_o, mem_wen_o); end
        tick();
        idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h1122_3344;
        #2;
        n_tests++; if (wb_valid_o !== 1'b1 || wb_wen_o !== 1'b1 || wb_rd_o !== 5'd4 || wb_data_o !== 32'h1122_3344)
            begin n_fail++; $display("FAIL sl_load_commit: got v=%b w=%b rd=%0d d=%h want 1/1/4/11223344", wb_valid_o, wb_wen_o, wb_rd_o, wb_data_o); end
        tick();
        idle();
        #2;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL sl_busy_after: got %b want 0", busy_o); end
    endtask

    task automatic test_err_reset();
        do_reset();
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #2;
        n_tests++; if (mem_ryumi_o !== 1'b0 || wb_valid_o !== 1'b0)
            begin n_fail++; $display("FAIL err_stray_ignored: got ry=%b wv=%b want 0/0", mem_ryumi_o, wb_valid_o); end
        tick();
        idle();
        #2;
        n_tests++; if (err_o !== 1'b1 || busy_o !== 1'b0)
            begin n_fail++; $display("FAIL err_set: got err=%b busy=%b want 1/0", err_o, busy_o); end
        tick();
        load_req(5'd1, 32'h80, 0);
        tick();
        load_req(5'd2, 32'h84, 0); mem_yumi_i = 1;
        tick();
        idle(); mem_yumi_i = 1;
        tick();
        idle();
        #2;
        n_tests++; if (err_o !== 1'b1 || busy_o !== 1'b1)
            begin n_fail++; $display("FAIL err_sticky_pending: got err=%b busy=%b want 1/1", err_o, busy_o); end
        reset = 1;
        tick();
        reset = 0;
        #2;
        n_tests++; if (busy_o !== 1'b0 || err_o !== 1'b0 || req_ready_o !== 1'b1 || mem_valid_o !== 1'b0)
            begin n_fail++; $display("FAIL err_after_reset: got busy=%b err=%b rdy=%b mv=%b want 0/0/1/0", busy_o, err_o, req_ready_o, mem_valid_o); end
    endtask

    task automatic test_random();
        bit          exp_ready, exp_ryumi, acc;
        logic [31:0] exp_data;
        pend_t       p;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid_i = ($urandom_range(0, 2) != 0);
            req_wen_i   = ($urandom_range(0, 2) == 0);
            req_byte_i  = $urandom_range(0, 1);
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            req_rd_i    = 5'($urandom_range(0, 31));
            mem_yumi_i  = m_hold_v ? ($urandom_range(0, 3) != 0) : (c >= 400 && $urandom_range(0, 49) == 0);
            mem_rvalid_i = (pq.size() != 0) ? ($urandom_range(0, 2) != 0) : (c >= 400 && $urandom_range(0, 49) == 0);
            mem_rdata_i = $urandom;
            wb_block_i  = ($urandom_range(0, 3) == 0);
            #2;
            exp_ready = (pq.size() < DEPTH) && (!m_hold_v || mem_yumi_i);
            exp_ryumi = mem_rvalid_i && (pq.size() != 0) && !wb_block_i;
            n_tests++; if (req_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready_o, exp_ready); end
            n_tests++; if (mem_valid_o !== m_hold_v) begin n_fail++; $display("FAIL rnd_mem_valid c%0d: got %b want %b", c, mem_valid_o, m_hold_v); end
            n_tests++; if (mem_ryumi_o !== exp_ryumi || wb_valid_o !== exp_ryumi)
                begin n_fail++; $display("FAIL rnd_ryumi c%0d: got ry=%b wv=%b want %b", c, mem_ryumi_o, wb_valid_o, exp_ryumi); end
            n_tests++; if (busy_o !== (m_hold_v || pq.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b", c, busy_o); end
            n_tests++; if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_o, m_err); end
            if (m_hold_v) begin
                n_tests++;
                if (mem_wen_o !== m_wen || mem_byte_o !== m_byte || mem_addr_o !== m_addr || mem_wdata_o !== m_wdata)
                    begin n_fail++; $display("FAIL rnd_hold c%0d: got %b %b %h %h want %b %b %h %h", c, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, m_wen, m_byte, m_addr, m_wdata); end
            end
            if (exp_ryumi) begin
                p = pq[0];
                exp_data = !p.is_load ? 32'h0 : (p.is_byte ? fmt_byte(mem_rdata_i) : mem_rdata_i);
                n_tests++;
                if (wb_wen_o !== p.is_load || wb_rd_o !== p.rd || wb_data_o !== exp_data)
                    begin n_fail++; $display("FAIL rnd_wb c%0d: got w=%b rd=%0d d=%h want %b/%0d/%h", c, wb_wen_o, wb_rd_o, wb_data_o, p.is_load, p.rd, exp_data); end
            end
            acc = req_valid_i && exp_ready;
            if ((mem_rvalid_i && pq.size() == 0) || (mem_yumi_i && !m_hold_v)) m_err = 1;
            if (exp_ryumi) pq.delete(0);
            if (acc) begin
                p.is_load = !req_wen_i; p.is_byte = req_byte_i; p.rd = req_rd_i;
                pq.push_back(p);
                m_hold_v = 1; m_wen = req_wen_i; m_byte = req_byte_i;
                m_addr = req_addr_i; m_wdata = req_wdata_i;
            end else if (mem_yumi_i) begin
                m_hold_v = 0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_single_load();
        test_full_queue();
        test_wb_block();
        test_byte_ext();
        test_store_load();
        test_err_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
